// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus between the fetch stage and its neighbours.
//   Decode -> fetch : stall, addr_sel, br_sel, special_addr_sel, flush,
//                     br_offset_raw, cond_offset_raw, reg_target
//   Instruction mem : imem_addr (out of fetch), imem_instr (into fetch)
//   IF/ID register  : id_instruction, id_pc, id_pc_plus4, id_valid
// modport master is the fetch stage side; modport slave is its environment.
interface fetch_stage_if;
   logic        stall;
   logic        addr_sel;
   logic        br_sel;
   logic        special_addr_sel;
   logic        flush;
   logic [25:0] br_offset_raw;
   logic [18:0] cond_offset_raw;
   logic [63:0] reg_target;
   logic [31:0] imem_instr;
   logic [63:0] imem_addr;
   logic [31:0] id_instruction;
   logic [63:0] id_pc;
   logic [63:0] id_pc_plus4;
   logic        id_valid;

   modport master (
      input  stall, addr_sel, br_sel, special_addr_sel, flush,
      input  br_offset_raw, cond_offset_raw, reg_target, imem_instr,
      output imem_addr, id_instruction, id_pc, id_pc_plus4, id_valid
   );

   modport slave (
      output stall, addr_sel, br_sel, special_addr_sel, flush,
      output br_offset_raw, cond_offset_raw, reg_target, imem_instr,
      input  imem_addr, id_instruction, id_pc, id_pc_plus4, id_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC (driven on imem_addr), captures the fetched word and its PC
// into IF/ID, computes branch targets from decode's controls and honours
// hazard stalls. Synchronous active-high reset.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   bus (master)     : decode controls, imem bus, IF/ID outputs
//   stall_cycles     : (FETCH_PERF_CNT_EN only) saturating stall count
//   bubble_cycles    : (FETCH_PERF_CNT_EN only) saturating flush count
// Parameters: RESET_PC (PC after reset), NOP_WORD (word injected into IF/ID).
// Optional feature macro: FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP_WORD = 32'h0
) (
   input  logic           clk,
   input  logic           reset,
   fetch_stage_if.master  bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]    stall_cycles,
   output logic [31:0]    bubble_cycles
`endif
);

   logic [63:0] pc;
   logic [31:0] id_instruction;
   logic [63:0] id_pc;
   logic        id_valid;

   logic [63:0] br_offset;
   logic [63:0] cond_offset;
   logic [63:0] target;

   // Word offsets scaled to bytes. Selection below is a true mux so that an
   // unselected (possibly X) offset never leaks into the PC.
   always_comb begin
      br_offset   = {{36{bus.br_offset_raw[25]}}, bus.br_offset_raw, 2'b00};
      cond_offset = {{43{bus.cond_offset_raw[18]}}, bus.cond_offset_raw, 2'b00};
      if (bus.special_addr_sel) begin
         target = bus.reg_target;
      end else if (bus.br_sel) begin
         target = id_pc + br_offset;
      end else begin
         target = id_pc + cond_offset;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= RESET_PC;
         id_instruction <= NOP_WORD;
         id_pc          <= 64'h0;
         id_valid       <= 1'b0;
      end else if (!bus.stall) begin
         pc    <= bus.addr_sel ? target : pc + 64'd4;
         id_pc <= pc;
         if (bus.flush) begin
            id_instruction <= NOP_WORD;
            id_valid       <= 1'b0;
         end else begin
            id_instruction <= bus.imem_instr;
            id_valid       <= 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles  <= 32'h0;
         bubble_cycles <= 32'h0;
      end else begin
         if (bus.stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (!bus.stall && bus.flush && (bubble_cycles != 32'hFFFF_FFFF)) begin
            bubble_cycles <= bubble_cycles + 32'd1;
         end
      end
   end
`endif

   assign bus.imem_addr      = pc;
   assign bus.id_instruction = id_instruction;
   assign bus.id_pc          = id_pc;
   assign bus.id_pc_plus4    = id_pc + 64'd4;
   assign bus.id_valid       = id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized stimulus for fetch_stage, checked
// against a behavioural model of the PC / IF/ID rules.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'hD503_201F;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] bubble_cycles;
   fetch_stage #(.RESET_PC(64'h0), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset), .bus(bus.master),
      .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles));
`else
   fetch_stage #(.RESET_PC(64'h0), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset), .bus(bus.master));
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
   endfunction

   assign bus.imem_instr = word_at(bus.imem_addr);

   // reference model state
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   logic [63:0] m_idpc;
   logic        m_valid;
   longint unsigned m_stalls;
   longint unsigned m_bubbles;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("imem_addr", bus.imem_addr, m_pc);
      check("id_instruction", {32'h0, bus.id_instruction}, {32'h0, m_instr});
      check("id_pc", bus.id_pc, m_idpc);
      check("id_pc_plus4", bus.id_pc_plus4, m_idpc + 64'd4);
      check("id_valid", {63'h0, bus.id_valid}, {63'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      check("stall_cycles", {32'h0, stall_cycles}, m_stalls);
      check("bubble_cycles", {32'h0, bubble_cycles}, m_bubbles);
`endif
   endtask

   // One clock: drive controls, advance the model by the fetch rules, compare.
   task automatic step(input logic rst, input logic st, input logic asel,
                       input logic bsel, input logic ssel, input logic fl,
                       input logic [25:0] br, input logic [18:0] cr,
                       input logic [63:0] rt);
      logic [63:0] tgt;
      @(negedge clk);
      reset                = rst;
      bus.stall            = st;
      bus.addr_sel         = asel;
      bus.br_sel           = bsel;
      bus.special_addr_sel = ssel;
      bus.flush            = fl;
      bus.br_offset_raw    = br;
      bus.cond_offset_raw  = cr;
      bus.reg_target       = rt;
      if (rst) begin
         m_pc = 64'h0; m_instr = NOP; m_idpc = 64'h0; m_valid = 1'b0;
         m_stalls = 0; m_bubbles = 0;
      end else if (st) begin
         if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
      end else begin
         if (ssel)      tgt = rt;
         else if (bsel) tgt = m_idpc + 64'(longint'($signed(br)) * 4);
         else           tgt = m_idpc + 64'(longint'($signed(cr)) * 4);
         m_idpc  = m_pc;
         m_instr = fl ? NOP : word_at(m_pc);
         m_valid = !fl;
         m_pc    = asel ? tgt : m_pc + 64'd4;
         if (fl && m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic seq();
      step(0, 0, 0, 0, 0, 0, 26'h0, 19'h0, 64'h0);
   endtask

   task automatic advance_to_idpc(input logic [63:0] want);
      int n = 0;
      while (m_idpc != want && n < 32) begin
         seq();
         n++;
      end
      check("reach_idpc", bus.id_pc, want);
   endtask

   initial begin
      m_stalls = 0; m_bubbles = 0;
      // reset state
      step(1, 0, 0, 0, 0, 0, 26'h0, 19'h0, 64'h0);
      step(1, 1, 1, 1, 0, 1, 26'h5, 19'h0, 64'h0);
      check("reset_pc", bus.imem_addr, 64'h0);
      check("reset_valid", {63'h0, bus.id_valid}, 64'h0);
      check("reset_nop", {32'h0, bus.id_instruction}, {32'h0, NOP});

      // sequential fetch after release
      seq();
      check("seq_pc4", bus.imem_addr, 64'h4);
      check("seq_valid", {63'h0, bus.id_valid}, 64'h1);
      seq();
      check("seq_pc8", bus.imem_addr, 64'h8);
      check("seq_idpc4", bus.id_pc, 64'h4);

      // unconditional branch at id_pc 0x10, offset -2 words
      advance_to_idpc(64'h10);
      step(0, 0, 1, 1, 0, 1, 26'h3FF_FFFE, 19'h0, 64'h0);
      check("ubr_target", bus.imem_addr, 64'h8);
      check("ubr_bubble", {63'h0, bus.id_valid}, 64'h0);
      check("ubr_nop", {32'h0, bus.id_instruction}, {32'h0, NOP});
      seq();
      check("ubr_target_in_id", bus.id_pc, 64'h8);

      // conditional branch at id_pc 0x20, +3 words
      advance_to_idpc(64'h20);
      step(0, 0, 1, 0, 0, 1, 26'h155_5555, 19'h00003, 64'h0);
      check("cond_target", bus.imem_addr, 64'h2C);

      // register target, offsets X
      step(0, 0, 1, 0, 1, 1, 'x, 'x, 64'h400);
      check("br_target", bus.imem_addr, 64'h400);

      // redirect without flush keeps the fetched word
      step(0, 0, 1, 0, 1, 0, 26'h0, 19'h0, 64'h800);
      check("redir_noflush_valid", {63'h0, bus.id_valid}, 64'h1);
      // flush without redirect: bubble, PC still advances
      step(0, 0, 0, 0, 0, 1, 26'h0, 19'h0, 64'h0);
      check("flush_seq_pc", bus.imem_addr, 64'h804);

      // stall with redirect and flush pending for three cycles
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 0, 1, 1, 26'h0, 19'h0, 64'h1000);
         check("stall_hold_pc", bus.imem_addr, 64'h804);
      end
      step(0, 0, 1, 0, 1, 1, 26'h0, 19'h0, 64'h1000);
      check("post_stall_redirect", bus.imem_addr, 64'h1000);

      // reset during a redirect edge
      step(1, 0, 1, 0, 1, 1, 26'h0, 19'h0, 64'h2000);
      check("reset_wins_pc", bus.imem_addr, 64'h0);
      check("reset_wins_valid", {63'h0, bus.id_valid}, 64'h0);
      seq();
      check("first_fetch_reset_pc", bus.id_pc, 64'h0);

      // PC wrap
      step(0, 0, 1, 0, 1, 0, 26'h0, 19'h0, 64'hFFFF_FFFF_FFFF_FFFC);
      seq();
      check("wrap_pc", bus.imem_addr, 64'h0);

`ifdef FETCH_PERF_CNT_EN
      step(1, 0, 0, 0, 0, 0, 26'h0, 19'h0, 64'h0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 26'h0, 19'h0, 64'h0);
      step(0, 0, 0, 0, 0, 1, 26'h0, 19'h0, 64'h0);
      step(0, 0, 1, 1, 0, 1, 26'h10, 19'h0, 64'h0);
      check("perf_stalls5", {32'h0, stall_cycles}, 64'd5);
      check("perf_bubbles2", {32'h0, bubble_cycles}, 64'd2);
      step(1, 1, 0, 0, 0, 1, 26'h0, 19'h0, 64'h0);
      check("perf_stall_clr", {32'h0, stall_cycles}, 64'd0);
      check("perf_bubble_clr", {32'h0, bubble_cycles}, 64'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic rs, st, as, bs, ss, fl;
         rs = ($urandom_range(0, 49) == 0);
         st = ($urandom_range(0, 3) == 0);
         as = ($urandom_range(0, 3) == 0);
         bs = $urandom_range(0, 1);
         ss = ($urandom_range(0, 4) == 0);
         fl = as ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 7) == 0);
         step(rs, st, as, bs, ss, fl, 26'($urandom), 19'($urandom),
              {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined ARM CPU, directly upstream of the instruction-decode controller. It holds the PC and drives the instruction-memory address. It captures the fetched word with its PC into the IF/ID register. It computes redirect targets from the decode stage's branch controls (`addr_sel`, `br_sel`, `special_addr_sel`, raw offsets, `flush`) and honours hazard stalls.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `NOP_WORD`, default 32'h0: word injected into IF/ID on a flush or reset; decodes as NOOP.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `stall`  in  1  hazard stall: hold PC and IF/ID.
- `addr_sel`  in  1  1 = redirect PC to the branch target; 0 = sequential.
- `br_sel`  in  1  1 = use `br_offset_raw`; 0 = use `cond_offset_raw`.
- `special_addr_sel`  in  1  1 = register target (BR); overrides `br_sel`.
- `flush`  in  1  kill the word being fetched this cycle.
- `br_offset_raw`  in  26  B/BL word offset, signed.
- `cond_offset_raw`  in  19  B.cond/CBZ word offset, signed.
- `reg_target`  in  64  BR target register value.
- `imem_instr`  in  32  instruction read combinationally at `imem_addr`.
- `imem_addr`  out  64  current PC.
- `id_instruction`  out  32  IF/ID instruction.
- `id_pc`  out  64  PC of `id_instruction`.
- `id_pc_plus4`  out  64  `id_pc` + 4, used as the BL link value.
- `id_valid`  out  1  0 when IF/ID holds an injected NOP.

## Operation
- Registered state is limited to: PC, `id_instruction`, `id_pc`, `id_valid`, and the optional counters.
- Target computation:
  - BR (`special_addr_sel`=1): target = `reg_target`.
  - Unconditional (`br_sel`=1): target = `id_pc` + (sext64(`br_offset_raw`) << 2).
  - Conditional (`br_sel`=0): target = `id_pc` + (sext64(`cond_offset_raw`) << 2).
  - All additions wrap modulo 2^64. Offsets are relative to the branch instruction's own PC, which is held in IF/ID.
- Update priority at each rising edge, highest first:
  1. `reset`: PC ← `RESET_PC`; `id_instruction` ← `NOP_WORD`; `id_pc` ← 0; `id_valid` ← 0.
  2. `stall`: all state holds. Redirect and flush are ignored, because decode outputs are not valid while stalled.
  3. Otherwise, PC ← target if `addr_sel`=1, else PC + 4 (wraps).
  4. In the same edge as step 3, IF/ID ← {`NOP_WORD`, `imem_addr`, valid 0} if `flush`=1, else {`imem_instr`, `imem_addr`, valid 1}.
- `flush`=1 with `addr_sel`=0 is legal: a bubble is inserted and the PC still advances by 4.
- `addr_sel`=1 with `flush`=0 is legal: the redirect happens and the fetched word is not killed.
- X values on unused raw offsets must not reach PC when they are not selected (mux, not arithmetic merge).

## Timing
- `imem_addr` equals the PC register. There is no combinational path from inputs to `imem_addr`.
- Fetch latency: a word at PC appears on `id_instruction` one cycle after PC is presented.
- Taken-branch penalty: exactly one bubble. The edge that sees `addr_sel`=1 and `flush`=1 loads the target into PC and loads a NOP into IF/ID. The target word reaches ID one cycle later.
- Stall: any number of consecutive cycles. Outputs are stable throughout; the first unstalled edge resumes exactly as if no stall occurred.
- Reset mid-operation (during a stall or a redirect) wins unconditionally. The first fetch after release is at `RESET_PC`.
- `id_pc_plus4` is combinational from `id_pc`.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
- Defined: adds outputs `stall_cycles` (32) and `bubble_cycles` (32).
  - Both are cleared by `reset`.
  - `stall_cycles` increments on each edge with `stall`=1 and `reset`=0.
  - `bubble_cycles` increments on each unstalled edge with `flush`=1 and `reset`=0.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, sequential fetch: after reset with `RESET_PC`=0, `imem_addr` steps 0, 4, 8. `id_pc` lags `imem_addr` by one cycle, and `id_valid` is 1 from the second edge onward.
- Unconditional branch: `id_pc`=0x10, `br_offset_raw`=26'h3FFFFFE (−2), `br_sel`=1, `addr_sel`=1, `flush`=1 → next `imem_addr`=0x08, next `id_valid`=0, next `id_instruction`=`NOP_WORD`.
- Conditional and register targets:
  - `cond_offset_raw`=19'h00003 at `id_pc`=0x20 → target 0x2C.
  - `special_addr_sel`=1 with `reg_target`=0x400 → target 0x400 (offsets driven X).
- Stall priority: `stall`=1 for 3 cycles with `addr_sel`=1 and `flush`=1 → PC and IF/ID unchanged. On the first unstalled edge, the redirect is taken.
- Reset mid-stream: assert `reset` during a redirect edge → PC=`RESET_PC`, `id_valid`=0. Wrap check: PC=64'hFFFFFFFFFFFFFFFC sequential → 0.
- With `FETCH_PERF_CNT_EN`: 5 stall cycles and 2 flushes → `stall_cycles`=5, `bubble_cycles`=2; reset clears both to 0.
